// File: rtl/result_writeback.sv
// result_writeback
//   Streams result tiles (SIZE x SIZE 32-bit elements) from a local tile
//   buffer to a row-major C matrix in memory. There is one DMA write burst
//   per tile row. Tiles are visited column-first inside each row band
//   (n_cnt inner, m_cnt outer). Rows and columns that fall outside the
//   m x n matrix are never written: out-of-range rows are skipped, and
//   out-of-range columns are masked through dma_wstrb.
//
// Ports
//   clk, rstn          clock; asynchronous active-low reset
//   start              begin write-back of one C matrix (ignored while busy)
//   addr_base_c        byte address of C[0][0]
//   m, n, ldc          rows, columns, row stride in bytes (captured on start)
//   tile_valid         a result tile is present in the buffer
//   tile_ready         one-cycle pulse: tile consumed, buffer may refill
//   buf_rd_en/row/beat buffer read strobe and location
//   buf_rd_data        buffer data, valid one cycle after buf_rd_en
//   dma_start/addr/len one-cycle burst request with byte address and beats
//   dma_wdata/wstrb    write beat and byte enables
//   dma_wvalid/wready  write beat handshake
//   dma_done           burst complete pulse
//   busy, done         job in progress; one-cycle completion pulse
module result_writeback #(
  parameter int SIZE   = 16,
  parameter int DATA_W = 256
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              start,
  input  logic [31:0]                       addr_base_c,
  input  logic [31:0]                       m,
  input  logic [31:0]                       n,
  input  logic [31:0]                       ldc,
  input  logic                              tile_valid,
  output logic                              tile_ready,
  output logic                              buf_rd_en,
  output logic [$clog2(SIZE)-1:0]           buf_rd_row,
  output logic [((SIZE*32/DATA_W) > 1 ? $clog2(SIZE*32/DATA_W) : 1)-1:0] buf_rd_beat,
  input  logic [DATA_W-1:0]                 buf_rd_data,
  output logic                              dma_start,
  output logic [31:0]                       dma_addr,
  output logic [7:0]                        dma_len,
  output logic [DATA_W-1:0]                 dma_wdata,
  output logic [DATA_W/8-1:0]               dma_wstrb,
  output logic                              dma_wvalid,
  input  logic                              dma_wready,
  input  logic                              dma_done,
  output logic                              busy,
  output logic                              done
);

  localparam int BEATS  = SIZE * 32 / DATA_W;
  localparam int ROW_W  = $clog2(SIZE);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int EPB    = DATA_W / 32;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE, WAIT_TILE, REQ, RD, DATA, WAIT_DONE
  } state_t;

  state_t state, state_nxt;

  logic [31:0]        base_q, m_q, n_q, ldc_q;
  logic [31:0]        m_cnt, n_cnt;
  logic [ROW_W-1:0]   row;
  logic [BEAT_W-1:0]  beat;
  logic               rd_pend;
  logic [DATA_W-1:0]  wdata_q;
  logic [STRB_W-1:0]  wstrb_q;
  logic               wvalid_q;
  logic               tile_ready_q;
  logic               done_q;

  logic [31:0]        row_abs;
  logic [31:0]        m_next, n_next;
  logic [31:0]        burst_addr;
  logic [31:0]        elem_base;
  logic [STRB_W-1:0]  strb_nxt;
  logic               more_rows, last_col, last_tile, last_beat, hs;

  // Tile and row bookkeeping (all 32-bit, wrapping)
  always_comb begin
    row_abs    = m_cnt + 32'(row);
    m_next     = m_cnt + 32'(SIZE);
    n_next     = n_cnt + 32'(SIZE);
    more_rows  = ((32'(row) + 32'd1) < 32'(SIZE)) && ((row_abs + 32'd1) < m_q);
    last_col   = !(n_next < n_q);
    last_tile  = last_col && !(m_next < m_q);
    last_beat  = (beat == BEAT_W'(BEATS - 1));
    hs         = wvalid_q && dma_wready;
    burst_addr = base_q + row_abs * ldc_q + (n_cnt << 2);
  end

  // Byte lane j covers element j/4 of the current beat; enabled only inside the matrix
  always_comb begin
    strb_nxt  = '0;
    elem_base = n_cnt + 32'(beat) * 32'(EPB);
    for (int unsigned j = 0; j < STRB_W; j++) begin
      strb_nxt[j] = (elem_base + 32'(j / 4)) < n_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start && (m != '0) && (n != '0)) state_nxt = WAIT_TILE;
      WAIT_TILE: if (tile_valid) state_nxt = REQ;
      REQ:       state_nxt = RD;
      RD:        state_nxt = DATA;
      DATA:      if (!rd_pend && hs) state_nxt = last_beat ? WAIT_DONE : RD;
      WAIT_DONE: begin
        if (dma_done) begin
          if (more_rows)      state_nxt = REQ;
          else if (last_tile) state_nxt = IDLE;
          else                state_nxt = WAIT_TILE;
        end
      end
      default:   state_nxt = IDLE;
    endcase
  end

  // DATA is entered with rd_pend set: the first DATA cycle only captures the
  // buffer word (available one cycle after the read), after which the beat is
  // held on the bus until the handshake.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      base_q       <= '0;
      m_q          <= '0;
      n_q          <= '0;
      ldc_q        <= '0;
      m_cnt        <= '0;
      n_cnt        <= '0;
      row          <= '0;
      beat         <= '0;
      rd_pend      <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      wvalid_q     <= 1'b0;
      tile_ready_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      tile_ready_q <= 1'b0;
      done_q       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_q <= addr_base_c;
            m_q    <= m;
            n_q    <= n;
            ldc_q  <= ldc;
            m_cnt  <= '0;
            n_cnt  <= '0;
            row    <= '0;
            beat   <= '0;
            if ((m == '0) || (n == '0)) done_q <= 1'b1;
          end
        end
        RD: rd_pend <= 1'b1;
        DATA: begin
          if (rd_pend) begin
            wdata_q  <= buf_rd_data;
            wstrb_q  <= strb_nxt;
            wvalid_q <= 1'b1;
            rd_pend  <= 1'b0;
          end else if (hs) begin
            wvalid_q <= 1'b0;
            beat     <= last_beat ? '0 : beat + BEAT_W'(1);
          end
        end
        WAIT_DONE: begin
          if (dma_done) begin
            if (more_rows) begin
              row <= row + ROW_W'(1);
            end else begin
              row          <= '0;
              tile_ready_q <= 1'b1;
              if (last_col) begin
                n_cnt <= '0;
                m_cnt <= m_next;
              end else begin
                n_cnt <= n_next;
              end
              if (last_tile) done_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign dma_start   = (state == REQ);
  assign dma_addr    = (state == REQ) ? burst_addr : '0;
  assign dma_len     = (state == REQ) ? 8'(BEATS) : '0;
  assign buf_rd_en   = (state == RD);
  assign buf_rd_row  = row;
  assign buf_rd_beat = beat;
  assign dma_wdata   = wdata_q;
  assign dma_wstrb   = wstrb_q;
  assign dma_wvalid  = wvalid_q;
  assign tile_ready  = tile_ready_q;
  assign done        = done_q;

endmodule

// File: doc/result_writeback.md
RESULT_WRITEBACK -- requirements
Module: result_writeback

Interface
REQ-001 Parameter SIZE, default 16, SHALL be the tile edge in elements (power of two, >=8).
REQ-002 Parameter DATA_W, default 256, SHALL be the DMA beat width; elements are 32-bit, so a tile row is SIZE*32/DATA_W beats (2 at defaults).
REQ-003 Ports (name  direction  width  meaning):
- clk  in  1  the single clock
- rstn  in  1  reset, asynchronous, active-low
- start  in  1  begin write-back of one C matrix
- addr_base_c  in  32  byte address of C[0][0]
- m, n  in  32 each  C rows, C columns
- ldc  in  32  C row stride in bytes
- tile_valid  in  1  result tile present in buffer
- tile_ready  out  1  one-cycle pulse: tile consumed, buffer may refill
- buf_rd_en  out  1  buffer read strobe
- buf_rd_row  out  log2(SIZE)  buffer row
- buf_rd_beat  out  log2(beats/row), min 1  beat within row
- buf_rd_data  in  DATA_W  buffer data, valid 1 cycle after buf_rd_en
- dma_start  out  1  one-cycle write-burst request
- dma_addr  out  32  burst byte address
- dma_len  out  8  burst length in beats
- dma_wdata  out  DATA_W  write data
- dma_wstrb  out  DATA_W/8  byte enables
- dma_wvalid  out  1  data valid
- dma_wready  in  1  DMA accepts beat
- dma_done  in  1  burst complete pulse
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse

Function
REQ-004 FSM states SHALL be IDLE, WAIT_TILE, REQ, RD, DATA, WAIT_DONE.
REQ-005 IDLE: start captures addr_base_c, m, n, ldc into internal registers, clears m_cnt, n_cnt, row; goes WAIT_TILE; start while busy SHALL be ignored.
REQ-006 start with m==0 or n==0 SHALL pulse done next cycle, stay IDLE, never assert dma_start.
REQ-007 Tile order: n_cnt inner, m_cnt outer, each stepping by SIZE while < n / < m; tile count = ceil(m/SIZE)*ceil(n/SIZE).
REQ-008 WAIT_TILE -> REQ when tile_valid high.
REQ-009 REQ: one-cycle dma_start with dma_addr = base + (m_cnt+row)*ldc + n_cnt*4 (mod 2^32), dma_len = beats/row; next state RD.
REQ-010 RD: buf_rd_en for one cycle with (row, beat); next state DATA; buf_rd_data registered into dma_wdata on the following edge with dma_wvalid set.
REQ-011 DATA: dma_wdata, dma_wstrb, dma_wvalid SHALL hold stable until dma_wvalid&dma_wready; then wvalid drops; last beat -> WAIT_DONE, else beat++ and -> RD (1 beat per >=2 cycles).
REQ-012 dma_wstrb lane j of beat b SHALL be 1 iff n_cnt + b*(DATA_W/32) + j/4 < n.
REQ-013 WAIT_DONE on dma_done: if row+1 < SIZE and m_cnt+row+1 < m, row++ -> REQ; else tile_ready pulse, row=0, advance tile counters; last tile -> done pulse, IDLE; otherwise -> WAIT_TILE.
REQ-014 Rows with m_cnt+row >= m SHALL never be requested; dma_done outside WAIT_DONE SHALL be ignored.
REQ-015 Input ports m, n, ldc, addr_base_c changing while busy SHALL have no effect.
REQ-016 All counter and address arithmetic SHALL be 32-bit unsigned, wrapping.

Reset
REQ-017 rstn low SHALL immediately force IDLE and zero every output and counter, including mid-burst; no pulse output SHALL fire on the deasserting edge.

Verification
REQ-018 m=16,n=16,ldc=64,base=0x1000, wready=1 -> 16 bursts at 0x1000..0x13C0 step 0x40, dma_len=2, all strobes 0xFFFFFFFF, one tile_ready, one done.
REQ-019 m=20,n=16,ldc=64 -> two tiles, 20 bursts, second tile 4 rows starting 0x1400, two tile_ready pulses, done after 20th dma_done.
REQ-020 m=16,n=12 -> each row beat0 strobe 0xFFFFFFFF, beat1 strobe 0x0000FFFF.
REQ-021 wready low 5 cycles per beat -> wdata/wstrb/wvalid unchanged across the stall, no extra buf_rd_en.
REQ-022 start with n=0 -> done one cycle later, no dma_start, busy stays low.
REQ-023 rstn asserted during DATA of second row -> outputs 0 same edge; new start after release runs REQ-018 cleanly.
